// File: rtl/branch_flag_unit.sv
// rtl/branch_flag_unit.sv - EX-stage flag register, conditional branch resolve and counted flush
module branch_flag_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       alu_flag,
  input  logic             flag_we,
  input  logic             br_valid,
  input  logic [2:0]       br_cond,
  input  logic [8:0]       br_offset,
  input  logic [15:0]      pc_plus1,
  output logic [2:0]       last_flag,
  output logic             taken,
  output logic [15:0]      target,
  output logic             flush,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [2:0]       FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t      state;
  logic [2:0]  cnt;
  logic [2:0]  eff;
  logic        z, v, n;
  logic        cond_ok;
  logic        br_take;
  logic [15:0] target_calc;

  // An ALU write in the same cycle is newer than the register, so bypass it.
  assign eff = flag_we ? alu_flag : last_flag;
  assign z   = eff[2];
  assign v   = eff[1];
  assign n   = eff[0];

  always_comb begin
    cond_ok = 1'b0;
    case (br_cond)
      3'b000:  cond_ok = z;
      3'b001:  cond_ok = !z;
      3'b010:  cond_ok = !z && (n == v);
      3'b011:  cond_ok = (n != v);
      3'b100:  cond_ok = (n == v);
      3'b101:  cond_ok = z || (n != v);
      3'b110:  cond_ok = v;
      default: cond_ok = 1'b1;
    endcase
  end

  // Gate on br_valid so condition/offset inputs are don't-care when no branch is present.
  assign br_take     = br_valid && cond_ok;
  assign target_calc = pc_plus1 + {{7{br_offset[8]}}, br_offset};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      last_flag <= 3'd0;
      taken     <= 1'b0;
      target    <= 16'd0;
      flush     <= 1'b0;
      taken_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flag_we) begin
            last_flag <= alu_flag;
          end
          if (br_take) begin
            taken  <= 1'b1;
            target <= target_calc;
            flush  <= 1'b1;
            cnt    <= FLUSH_INIT;
            if (taken_cnt != CNT_MAX) begin
              taken_cnt <= taken_cnt + CNT_ONE;
            end
            state <= (FLUSH_CYCLES == 1) ? IDLE : FLUSH;
          end else begin
            taken <= 1'b0;
            flush <= 1'b0;
          end
        end
        FLUSH: begin
          // Anything in EX here is squashed: its branch and flag write are dropped.
          taken <= 1'b0;
          if (cnt == 3'd0) begin
            flush <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          flush <= 1'b0;
          taken <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/branch_flag_unit.md
Name: branch_flag_unit

Overview:
- Consumer side of the ALU condition-flag interface.
- Holds the architectural flag register that is written from the ALU flag output and fed back to the ALU as lastFlag.
- Evaluates conditional branches against the current flags, computes the branch target, and drives a counted pipeline flush after each taken branch.
- Sits in the EX stage beside the alu, between the ALU and the PC/fetch logic.

Parameters:
- FLUSH_CYCLES, 2, number of cycles flush stays high after a taken branch; legal range 1..7.
- CNT_W, 16, width of the saturating taken-branch counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- alu_flag  input  3  flags from the ALU: [2]=Z, [1]=V, [0]=N.
- flag_we  input  1  ALU instruction in EX writes flags this cycle.
- br_valid  input  1  conditional branch in EX this cycle.
- br_cond  input  3  condition code.
- br_offset  input  9  signed word offset.
- pc_plus1  input  16  address of the branch plus 1.
- last_flag  output  3  registered flag register; drives alu lastFlag.
- taken  output  1  registered; branch resolved taken.
- target  output  16  registered branch target; valid while taken=1.
- flush  output  1  squash younger instructions and redirect fetch.
- taken_cnt  output  CNT_W  count of taken branches, saturating.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - last_flag=0, taken=0, target=0, flush=0, taken_cnt=0, state=IDLE.
  - Reset overrides every other input, including mid-FLUSH: the flush is aborted on that same edge.
- Flag register:
  - In IDLE with flag_we=1, last_flag <= alu_flag at the edge.
  - In FLUSH, flag_we is ignored because the writer is a squashed instruction.
- Effective flags (eff) for evaluation:
  - eff = alu_flag when flag_we=1 in the same cycle (bypass, newest wins).
  - Otherwise eff = last_flag.
- Conditions, with Z,V,N taken from eff:
  - 000 EQ: Z.
  - 001 NE: !Z.
  - 010 GT: !Z & (N==V).
  - 011 LT: N!=V.
  - 100 GE: N==V.
  - 101 LE: Z | (N!=V).
  - 110 VS: V.
  - 111 AL: 1.
- Target = pc_plus1 + sign_extend(br_offset) mod 2^16. Wrap-around is silent: 0xFFFF+1 = 0x0000.
- Latency: branch sampled in cycle t; taken/target/flush visible in cycle t+1.
- State machine:
  - IDLE: if br_valid and condition true, then at the edge:
    - taken<=1, target<=computed value, flush<=1, counter<=FLUSH_CYCLES-1.
    - taken_cnt increments, saturating at all-ones.
    - Next state is FLUSH, or stays IDLE with flush for exactly 1 cycle when FLUSH_CYCLES=1.
  - IDLE, br_valid with condition false: taken<=0, flush<=0, target holds its old value.
  - IDLE, no br_valid: taken<=0, flush<=0.
  - FLUSH: flush=1 and taken=0 after the first flush cycle. The counter decrements each cycle; on 0, return to IDLE with flush<=0.
  - FLUSH: br_valid is ignored (squashed); no new taken, no counter increment.
- Total flush duration is exactly FLUSH_CYCLES consecutive cycles, starting at t+1.
- A branch arriving in the first IDLE cycle after a flush is evaluated normally, so back-to-back flush windows are allowed.
- taken is a 1-cycle pulse per taken branch.
- Unknown or X inputs while br_valid=0 must not affect any output.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with random inputs -> all outputs 0. Release, then flag_we=1, alu_flag=3'b100 -> last_flag=3'b100 one cycle later.
- Bypass: last_flag=000; same cycle flag_we=1, alu_flag=100, br_valid=1, br_cond=000 (EQ), pc_plus1=0x0010, br_offset=9'h1F0 (-16) -> next cycle taken=1, target=0x0000, flush=1 for 2 cycles, taken_cnt=1.
- Not taken: last_flag=001 (N=1,V=0), br_cond=100 (GE) -> taken=0, flush=0, target unchanged.
- Wrap and flush squash: pc_plus1=0xFFFF, br_offset=+1, cond=111 -> target=0x0000. A second br_valid=1 AL during the flush window -> ignored, taken_cnt stays +1. A flag_we during flush -> last_flag unchanged.
- Reset mid-flush: rst_n=0 in the second flush cycle -> flush=0 and state IDLE at the next edge. A branch immediately after release resolves normally.
- Condition sweep plus saturation:
  - All 8 conds x 8 flag values compared against the reference equations above.
  - Preload taken_cnt near 0xFFFF via repeated AL branches -> counter holds at 0xFFFF.
